// File: rtl/alt_dprio_responder_sv.sv
// DPRIO responder model: a bank of 16-bit PMA configuration registers answering
// one address window of one quad, with a fixed busy latency per access.
module alt_dprio_responder_sv #(
    parameter int          addr_width          = 4,
    parameter int          access_latency      = 4,
    parameter logic [11:0] pma_base_address    = 12'h0,
    parameter logic [8:0]  quad_id             = 9'h0,
    parameter logic [15:0] reset_value         = 16'h0000,
    parameter logic [15:0] unmapped_read_value = 16'hDEAD
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] dprio_addr,
    input  logic [15:0] dprio_datain,
    input  logic        dprio_rden,
    input  logic        dprio_wren,
    input  logic [8:0]  quad_addr,
    output logic        dprio_busy,
    output logic [15:0] dprio_dataout,
    output logic        dprio_err,
    output logic [15:0] access_count
);

    localparam int          depth     = 1 << addr_width;
    localparam logic [15:0] base_full = {4'b0000, pma_base_address};
    localparam logic [3:0]  busy_load = 4'(access_latency - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t state, state_next;
    logic [3:0] busy_cnt, busy_cnt_next;
    logic       err_next;

    logic                  op_write;
    logic                  op_hit;
    logic [addr_width-1:0] op_offset;
    logic [15:0]           op_data;

    logic [15:0] regs [depth];

    logic quad_hit;
    logic window_hit;
    logic any_strobe;
    logic accept;
    logic complete;

    assign quad_hit   = (quad_addr == quad_id);
    assign window_hit = (dprio_addr[15:addr_width] == base_full[15:addr_width]);
    assign any_strobe = dprio_rden | dprio_wren;
    assign accept     = (state == IDLE) && (dprio_rden ^ dprio_wren) && quad_hit;
    assign complete   = (state == BUSY) && (busy_cnt == 4'd0);
    assign dprio_busy = (state == BUSY);

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        busy_cnt_next = busy_cnt;
        err_next      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next    = BUSY;
                    busy_cnt_next = busy_load;
                end else if (dprio_rden && dprio_wren && quad_hit) begin
                    err_next = 1'b1;
                end
            end
            BUSY: begin
                // Strobes arriving mid-access are flagged but never disturb it.
                if (any_strobe) err_next = 1'b1;
                if (busy_cnt == 4'd0) begin
                    state_next = IDLE;
                    if (!op_hit) err_next = 1'b1;
                end else begin
                    busy_cnt_next = busy_cnt - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy_cnt  <= 4'd0;
            dprio_err <= 1'b0;
        end else begin
            state     <= state_next;
            busy_cnt  <= busy_cnt_next;
            dprio_err <= err_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_write  <= 1'b0;
            op_hit    <= 1'b0;
            op_offset <= '0;
            op_data   <= 16'h0000;
        end else if (accept) begin
            op_write  <= dprio_wren;
            op_hit    <= window_hit;
            op_offset <= dprio_addr[addr_width-1:0];
            op_data   <= dprio_datain;
        end
    end

    // NOTE: the register bank is built from flops, not RAM, because every
    // entry must return to reset_value on reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < depth; i++) regs[i] <= reset_value;
        end else if (complete && op_write && op_hit) begin
            regs[op_offset] <= op_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dprio_dataout <= 16'h0000;
            access_count  <= 16'h0000;
        end else if (complete) begin
            access_count <= access_count + 16'd1;
            if (!op_write) dprio_dataout <= op_hit ? regs[op_offset] : unmapped_read_value;
        end
    end

endmodule
